display_update_arbiter: RTL and testbench
=========================================

# display_update_arbiter

Round-robin arbiter and sequencer that shares the single 32-bit display-value register between NREQ style-resolution requesters. Each cycle it picks at most one requester. It gates the load with the primitive/valid qualification: load only when is_primitive_value & is_valid_display_value. It then presents the committed value downstream through a valid/ready handshake. The block sits between the style-resolution units and the display-value consumer, and it keeps a wrapping count of committed updates.

## Interface
- NREQ, 4, number of requesters (2..8); the source index width is SW = clog2(NREQ)
- clock  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clock
- req  in  NREQ  per-requester update request, level; held until gnt or rej
- value  in  32*NREQ  flattened candidate values; requester i uses bits [32i+31:32i]
- is_primitive_value  in  NREQ  per-requester qualifier
- is_valid_display_value  in  NREQ  per-requester qualifier
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted and loaded
- rej  out  NREQ  one-hot, one-cycle pulse: request dropped because it failed qualification
- out_valid  out  1  out_value holds an uncollected update
- out_ready  in  1  consumer accepts when out_valid & out_ready at a rising edge
- out_value  out  32  committed display value
- out_src  out  SW  index of the requester that produced out_value
- commit_count  out  32  number of completed out handshakes, wraps modulo 2^32

## Operation
- State is IDLE (out_valid=0) or FULL (out_valid=1).
- An arbitration edge is any rising edge with reset=1 where state==IDLE, or where state==FULL && out_ready==1.
- Eligibility mask: req[i] & ~gnt[i] & ~rej[i]. A requester is ignored in the cycle its own gnt or rej is showing, so a held req is never double-served.
- Winner selection: the first eligible index searched circularly from ptr+1 upward. ptr is the last winner, whether granted or rejected.
- At an arbitration edge with winner w:
  - ptr<=w.
  - If is_primitive_value[w] & is_valid_display_value[w], sampled at that edge:
    - out_value<=value[w], out_src<=w.
    - gnt<=onehot(w), state<=FULL.
  - Otherwise:
    - rej<=onehot(w); out_value and out_src are unchanged.
    - state<=FULL if a handshake occurred at this edge and... no, state<=IDLE.
- At an arbitration edge with no eligible requester: gnt and rej are 0, ptr is unchanged, and state<=IDLE if the edge was a handshake.
- Handshake (FULL && out_ready at an edge) increments commit_count by 1. It is simultaneous with the arbitration at the same edge, which gives back-to-back throughput of one update per cycle.
- In FULL with out_ready=0: out_value, out_src and out_valid hold, req is not sampled, and gnt and rej are 0.
- gnt and rej are never both nonzero, and at most one bit of either is set.

## Timing
- Reset (reset=0 at an edge), on the next cycle:
  - state=IDLE, out_valid=0.
  - out_value=0, out_src=0, commit_count=0, gnt=0, rej=0.
  - ptr=NREQ-1, so requester 0 has first priority.
  - Reset overrides any handshake or arbitration at the same edge.
- Reset mid-operation drops a pending FULL value without counting it.
- Latency: req sampled at edge E leads to gnt/rej and out_valid visible in the cycle after E (1 cycle).
- A requester must keep req and its value/qualifiers stable until it sees gnt or rej. It may deassert req in the gnt/rej cycle.
- out_value, out_src and out_valid change only at arbitration edges or reset.
- commit_count 0xFFFFFFFF + handshake gives 0x00000000.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset then single request: hold reset=0 for 2 cycles, release.
  - Stimulus: req=4'b0100, value[2]=0x12345678, qualifiers 1, out_ready=1.
  - Response: next cycle gnt=4'b0100, out_valid=1, out_value=0x12345678, out_src=2. The following edge gives commit_count=1 and out_valid=0.
- Round-robin fairness: req=4'b1111 held continuously, all qualified, out_ready=1.
  - Response: gnt sequence 0001, 0100, 0001, ... is wrong; the required sequence is 0001, 0010, 0100, 1000, 0001 (each requester re-eligible after its gnt cycle), one grant per cycle, commit_count +1 per cycle.
- Qualification reject: req[1]=1 with is_primitive_value[1]=1, is_valid_display_value[1]=0.
  - Response: rej=4'b0010 for one cycle, gnt=0, out_valid stays 0, out_value unchanged, commit_count unchanged.
- Backpressure: two qualified requests (req0 value 0xA, req3 value 0xB), out_ready=0 for 5 cycles, then 1.
  - Response: out_value=0xA held for 5 cycles with only one gnt (0001). At the release edge commit_count=1, and the next cycle shows gnt=1000 and out_value=0xB.
- Reset mid-FULL: out_valid=1 with out_ready=0, then assert reset=0 together with out_ready=1.
  - Response: next cycle out_valid=0, commit_count=0, ptr restarts with requester 0 first.
- Counter wrap: force commit_count=0xFFFFFFFF via 2^32-1 handshakes (or a bench force), then one more handshake.
  - Response: commit_count=0x00000000.

Source files
------------

// File: rtl/display_update_arbiter.sv
// Round-robin arbiter that shares one 32-bit display-value register between
// NREQ style-resolution requesters and hands committed values downstream.
module display_update_arbiter #(
  parameter int NREQ = 4,
  parameter int SW   = $clog2(NREQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   value,
  input  logic [NREQ-1:0]      is_primitive_value,
  input  logic [NREQ-1:0]      is_valid_display_value,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rej,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_value,
  output logic [SW-1:0]        out_src,
  output logic [31:0]          commit_count
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]   LAST = SW'(NREQ - 1);

  state_t          state;
  logic [SW-1:0]   ptr;
  logic [31:0]     count;

  logic [NREQ-1:0] eligible;
  logic            found;
  logic [SW-1:0]   win;
  logic            qualified;
  logic [31:0]     win_value;
  logic            arb_edge;
  logic            handshake;

  // A requester showing its own gnt/rej this cycle is masked so a held req
  // is not served twice.
  assign eligible  = req & ~gnt & ~rej;
  assign arb_edge  = (state == IDLE) || out_ready;
  assign handshake = (state == FULL) && out_ready;

  // NOTE: every always_comb output gets a default before any conditional
  // update, otherwise synthesis infers latches for the unassigned paths.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
  end

  assign qualified = is_primitive_value[win] & is_valid_display_value[win];
  assign win_value = value[32*int'(win) +: 32];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= LAST;
      count     <= '0;
      out_value <= '0;
      out_src   <= '0;
      gnt       <= '0;
      rej       <= '0;
    end else begin
      gnt <= '0;
      rej <= '0;
      if (handshake) begin
        count <= count + 32'd1;
      end
      if (arb_edge) begin
        if (found) begin
          ptr <= win;
          if (qualified) begin
            out_value <= win_value;
            out_src   <= win;
            gnt       <= ONE << win;
            state     <= FULL;
          end else begin
            rej   <= ONE << win;
            state <= IDLE;
          end
        end else begin
          state <= IDLE;
        end
      end
    end
  end

  assign out_valid    = (state == FULL);
  assign commit_count = count;

endmodule

// File: tb/tb_display_update_arbiter.sv
// Directed bench for display_update_arbiter: reset, single request, round
// robin, reject, backpressure, reset while FULL and counter wrap.
module tb_display_update_arbiter;

  localparam int NREQ = 4;
  localparam int SW   = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [32*NREQ-1:0]  value;
  logic [NREQ-1:0]     is_primitive_value;
  logic [NREQ-1:0]     is_valid_display_value;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rej;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_value;
  logic [SW-1:0]       out_src;
  logic [31:0]         commit_count;

  int vectors = 0;
  int errors  = 0;

  display_update_arbiter #(.NREQ(NREQ)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .req                    (req),
    .value                  (value),
    .is_primitive_value     (is_primitive_value),
    .is_valid_display_value (is_valid_display_value),
    .gnt                    (gnt),
    .rej                    (rej),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .out_value              (out_value),
    .out_src                (out_src),
    .commit_count           (commit_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset                  = 1'b0;
    req                    = '0;
    value                  = '0;
    is_primitive_value     = '1;
    is_valid_display_value = '1;
    out_ready              = 1'b1;

    // Reset held for two edges
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rej", 32'(rej), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_value", out_value, 32'h0);
    check("rst_src", 32'(out_src), 32'h0);
    check("rst_count", commit_count, 32'h0);

    // Single request from requester 2
    reset            = 1'b1;
    req              = 4'b0100;
    value[64 +: 32]  = 32'h1234_5678;
    tick();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_value", out_value, 32'h1234_5678);
    check("single_src", 32'(out_src), 32'h2);
    req = '0;
    tick();
    check("single_count", commit_count, 32'h1);
    check("single_valid_drop", 32'(out_valid), 32'h0);
    check("single_gnt_clear", 32'(gnt), 32'h0);

    // Round robin with all four requesters held
    do_reset();
    for (int i = 0; i < NREQ; i++) value[32*i +: 32] = 32'h100 + 32'(i);
    req = 4'b1111;
    tick();
    check("rr0_gnt", 32'(gnt), 32'h1);
    check("rr0_value", out_value, 32'h100);
    check("rr0_count", commit_count, 32'h0);
    tick();
    check("rr1_gnt", 32'(gnt), 32'h2);
    check("rr1_value", out_value, 32'h101);
    check("rr1_count", commit_count, 32'h1);
    tick();
    check("rr2_gnt", 32'(gnt), 32'h4);
    check("rr2_src", 32'(out_src), 32'h2);
    check("rr2_count", commit_count, 32'h2);
    tick();
    check("rr3_gnt", 32'(gnt), 32'h8);
    check("rr3_value", out_value, 32'h103);
    check("rr3_count", commit_count, 32'h3);
    tick();
    check("rr4_gnt", 32'(gnt), 32'h1);
    check("rr4_count", commit_count, 32'h4);
    req = '0;
    tick();
    check("rr_end_count", commit_count, 32'h5);
    check("rr_end_valid", 32'(out_valid), 32'h0);

    // Qualification reject on requester 1
    req                       = 4'b0010;
    is_valid_display_value[1] = 1'b0;
    tick();
    check("rej_rej", 32'(rej), 32'h2);
    check("rej_gnt", 32'(gnt), 32'h0);
    check("rej_valid", 32'(out_valid), 32'h0);
    check("rej_value", out_value, 32'h100);
    check("rej_count", commit_count, 32'h5);
    req                       = '0;
    is_valid_display_value[1] = 1'b1;
    tick();
    check("rej_pulse", 32'(rej), 32'h0);

    // Backpressure: requesters 0 and 3, consumer stalled for five cycles
    do_reset();
    value[0 +: 32]  = 32'hA;
    value[96 +: 32] = 32'hB;
    req             = 4'b1001;
    out_ready       = 1'b0;
    tick();
    check("bp_gnt", 32'(gnt), 32'h1);
    check("bp_value", out_value, 32'hA);
    req = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_gnt", 32'(gnt), 32'h0);
      check("bp_hold_value", out_value, 32'hA);
      check("bp_hold_valid", 32'(out_valid), 32'h1);
    end
    check("bp_hold_count", commit_count, 32'h0);
    out_ready = 1'b1;
    tick();
    check("bp_rel_count", commit_count, 32'h1);
    check("bp_rel_gnt", 32'(gnt), 32'h8);
    check("bp_rel_value", out_value, 32'hB);
    check("bp_rel_src", 32'(out_src), 32'h3);
    req = '0;
    tick();
    check("bp_end_count", commit_count, 32'h2);

    // Reset while FULL and stalled
    value[0 +: 32] = 32'hC;
    req            = 4'b0001;
    out_ready      = 1'b0;
    tick();
    check("mid_full", 32'(out_valid), 32'h1);
    req       = '0;
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    check("mid_valid", 32'(out_valid), 32'h0);
    check("mid_count", commit_count, 32'h0);
    check("mid_value", out_value, 32'h0);
    reset = 1'b1;
    req   = 4'b1111;
    tick();
    check("mid_first", 32'(gnt), 32'h1);
    req = '0;
    tick();
    check("mid_count1", commit_count, 32'h1);

    // Counter wrap via a preloaded count
    force dut.count = 32'hFFFF_FFFF;
    release dut.count;
    #1;
    check("wrap_pre", commit_count, 32'hFFFF_FFFF);
    req = 4'b0001;
    tick();
    check("wrap_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    check("wrap_count", commit_count, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
